// File: rtl/dmem_pkg.sv
// dmem_pkg: access type codes, arbiter states and access legality for dmem_arbiter.
package dmem_pkg;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} arb_state_t;

   // Halfword codes share low bits 01, so one alignment term covers LH, LHU and SH.
   function automatic logic is_legal(input logic we, input logic [2:0] t, input logic [1:0] a);
      logic type_ok;
      type_ok = we ? (t == SB || t == SH || t == SW)
                   : (t == LB || t == LH || t == LW || t == LBU || t == LHU);
      return type_ok && !(t[1:0] == 2'b01 && a[0]) && !(t == LW && a != 2'b00);
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr2.sv
// arb_rr2: two-way picker, round-robin or fixed m0 priority; a forced turn
// makes the next arbitration follow the pointer even under fixed priority.
module arb_rr2 #(
   parameter int FIXED_PRIO = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       upd_i,
   input  logic       upd_idx_i,
   input  logic       force_i,
   output logic [1:0] gnt_o
);

   logic ptr_q, ptr_d, forced_q, forced_d, pri1;

   assign pri1     = (FIXED_PRIO != 0 && !forced_q) ? 1'b0 : ptr_q;
   assign gnt_o    = {req_i[1] & (~req_i[0] | pri1), req_i[0] & (~req_i[1] | ~pri1)};
   assign ptr_d    = upd_i ? ~upd_idx_i : ptr_q;
   assign forced_d = force_i | (forced_q & ~upd_i);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ptr_q    <= 1'b0;
         forced_q <= 1'b0;
      end else begin
         ptr_q    <= ptr_d;
         forced_q <= forced_d;
      end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between m0 and m1 with
// same-cycle grant, registered one-cycle responses and a bounded ownership lock.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int FIXED_PRIO = 0,
   parameter int LOCK_MAX   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_req_i,
   input  logic        m1_req_i,
   input  logic        m0_we_i,
   input  logic        m1_we_i,
   input  logic [2:0]  m0_type_i,
   input  logic [2:0]  m1_type_i,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m0_wdata_i,
   input  logic [31:0] m1_wdata_i,
   input  logic        m0_lock_i,
   input  logic        m1_lock_i,
   output logic        m0_gnt_o,
   output logic        m1_gnt_o,
   output logic        m0_rvalid_o,
   output logic        m1_rvalid_o,
   output logic [31:0] m0_rdata_o,
   output logic [31:0] m1_rdata_o,
   output logic        m0_err_o,
   output logic        m1_err_o,
   output logic        d_wr_en_o,
   output logic [2:0]  store_type_o,
   output logic [2:0]  load_type_o,
   output logic [31:0] dAddr_o,
   output logic [31:0] dWdata_o,
   input  logic [31:0] dRdata_i
);

   localparam logic [7:0] LMAX = 8'(LOCK_MAX);

   arb_state_t  state_q;
   logic [7:0]  lock_cnt_q, lock_cnt_d;
   logic [1:0]  req, pick, gnt, rvalid_q, err_q;
   logic [31:0] rdata_q [2];
   logic        act, w, w_we, w_lock, legal, expire, own_idle;
   logic [2:0]  w_type;
   logic [31:0] w_addr, w_wdata;

   assign req = {m1_req_i, m0_req_i};
   assign gnt = !rst_n            ? 2'b00 :
                state_q == IDLE   ? pick :
                state_q == LOCK0  ? {1'b0, req[0]} : {req[1], 1'b0};
   assign act     = |gnt;
   assign w       = gnt[1];
   assign w_we    = w ? m1_we_i    : m0_we_i;
   assign w_type  = w ? m1_type_i  : m0_type_i;
   assign w_addr  = w ? m1_addr_i  : m0_addr_i;
   assign w_wdata = w ? m1_wdata_i : m0_wdata_i;
   assign w_lock  = w ? m1_lock_i  : m0_lock_i;
   assign legal   = is_legal(w_we, w_type, w_addr[1:0]);

   // Beat count including the current beat; entry from IDLE is beat 1.
   assign lock_cnt_d = state_q == IDLE     ? 8'd1 :
                       lock_cnt_q == 8'hFF ? 8'hFF : lock_cnt_q + 8'd1;
   assign expire   = act & w_lock & (lock_cnt_d >= LMAX);
   assign own_idle = state_q == LOCK1 ? ~m1_req_i & ~m1_lock_i : ~m0_req_i & ~m0_lock_i;

   arb_rr2 #(.FIXED_PRIO(FIXED_PRIO)) u_rr (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req),
      .upd_i     (act),
      .upd_idx_i (w),
      .force_i   (expire),
      .gnt_o     (pick)
   );

   assign m0_gnt_o     = gnt[0];
   assign m1_gnt_o     = gnt[1];
   assign d_wr_en_o    = act & w_we & legal;
   assign store_type_o = act &  w_we ? w_type : 3'b000;
   assign load_type_o  = act & ~w_we ? w_type : 3'b000;
   assign dAddr_o      = act ? w_addr  : '0;
   assign dWdata_o     = act ? w_wdata : '0;
   assign m0_rvalid_o  = rvalid_q[0];
   assign m1_rvalid_o  = rvalid_q[1];
   assign m0_err_o     = err_q[0];
   assign m1_err_o     = err_q[1];
   assign m0_rdata_o   = rdata_q[0];
   assign m1_rdata_o   = rdata_q[1];

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q    <= IDLE;
         lock_cnt_q <= '0;
         rvalid_q   <= '0;
         err_q      <= '0;
         rdata_q[0] <= '0;
         rdata_q[1] <= '0;
      end else begin
         rvalid_q   <= gnt;
         err_q      <= gnt & {2{~legal}};
         rdata_q[0] <= (gnt[0] & legal & ~w_we) ? dRdata_i : '0;
         rdata_q[1] <= (gnt[1] & legal & ~w_we) ? dRdata_i : '0;
         if (act && w_lock && !expire) begin
            state_q    <= w ? LOCK1 : LOCK0;
            lock_cnt_q <= lock_cnt_d;
         end else if (state_q != IDLE && (act || own_idle)) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
         end
      end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter against a
// rule-level arbitration/lock/memory model.
module tb_dmem_arbiter;

   localparam int FIXED_PRIO = 0;
   localparam int LOCK_MAX   = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req, we, lock;
   logic [2:0]  typ [2];
   logic [31:0] addr [2];
   logic [31:0] wdata [2];
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, d_wr_en;
   logic [31:0] m0_rdata, m1_rdata, dAddr, dWdata, dRdata;
   logic [2:0]  store_type, load_type;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model state
   int          owner, beats, pref, last_win;
   bit          forced;
   logic [1:0]  erv, eerr, obs_gnt;
   logic [31:0] erd [2];
   logic [31:0] rmem [16];
   logic [31:0] mem [16];

   always #5 clk = ~clk;

   dmem_arbiter #(.FIXED_PRIO(FIXED_PRIO), .LOCK_MAX(LOCK_MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req_i(req[0]), .m1_req_i(req[1]),
      .m0_we_i(we[0]), .m1_we_i(we[1]),
      .m0_type_i(typ[0]), .m1_type_i(typ[1]),
      .m0_addr_i(addr[0]), .m1_addr_i(addr[1]),
      .m0_wdata_i(wdata[0]), .m1_wdata_i(wdata[1]),
      .m0_lock_i(lock[0]), .m1_lock_i(lock[1]),
      .m0_gnt_o(m0_gnt), .m1_gnt_o(m1_gnt),
      .m0_rvalid_o(m0_rvalid), .m1_rvalid_o(m1_rvalid),
      .m0_rdata_o(m0_rdata), .m1_rdata_o(m1_rdata),
      .m0_err_o(m0_err), .m1_err_o(m1_err),
      .d_wr_en_o(d_wr_en), .store_type_o(store_type), .load_type_o(load_type),
      .dAddr_o(dAddr), .dWdata_o(dWdata), .dRdata_i(dRdata)
   );

   function automatic logic [31:0] load_val(logic [31:0] w, logic [2:0] t, logic [1:0] a);
      logic [31:0] s;
      s = w >> {a, 3'b000};
      case (t)
         3'd0:    return {{24{s[7]}}, s[7:0]};
         3'd4:    return {24'b0, s[7:0]};
         3'd1:    return {{16{s[15]}}, s[15:0]};
         3'd5:    return {16'b0, s[15:0]};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] store_merge(logic [31:0] w, logic [2:0] t, logic [1:0] a, logic [31:0] d);
      logic [31:0] m;
      m = t == 3'd0 ? 32'hFF << {a, 3'b000} : t == 3'd1 ? 32'hFFFF << {a, 3'b000} : 32'hFFFF_FFFF;
      return (w & ~m) | ((d << {a, 3'b000}) & m);
   endfunction

   function automatic bit legal(logic w, logic [2:0] t, logic [1:0] a);
      case (t)
         3'd0:    return 1'b1;
         3'd1:    return a[0] == 1'b0;
         3'd2:    return a == 2'b00;
         3'd4:    return !w;
         3'd5:    return !w && a[0] == 1'b0;
         default: return 1'b0;
      endcase
   endfunction

   // Memory behind the arbiter: combinational formatted read, store at clock edge
   always @(posedge clk)
      if (!rst_n) for (int i = 0; i < 16; i++) mem[i] <= '0;
      else if (d_wr_en) mem[dAddr[5:2]] <= store_merge(mem[dAddr[5:2]], store_type, dAddr[1:0], dWdata);
   assign dRdata = load_val(mem[dAddr[5:2]], load_type, dAddr[1:0]);

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      owner = -1; beats = 0; pref = 0; forced = 0; last_win = -1;
      erv = '0; eerr = '0; erd[0] = '0; erd[1] = '0;
      for (int i = 0; i < 16; i++) rmem[i] = '0;
   endtask

   task automatic set_req(int m, logic r, logic w, logic [2:0] t, logic [31:0] a, logic [31:0] d, logic l);
      req[m] = r; we[m] = w; typ[m] = t; addr[m] = a; wdata[m] = d; lock[m] = l;
   endtask

   // Called at a negedge with inputs applied; checks one cycle and advances to the next negedge.
   task automatic step();
      int win;
      bit ok, e_wr;
      logic [31:0] e_addr, e_wd;
      logic [2:0] e_st, e_lt;
      #1;
      check("rvalid", 32'({m1_rvalid, m0_rvalid}), 32'(erv));
      check("err", 32'({m1_err, m0_err}), 32'(eerr));
      check("rdata0", m0_rdata, erd[0]);
      check("rdata1", m1_rdata, erd[1]);
      if (owner < 0)
         win = (req[0] && req[1]) ? ((FIXED_PRIO != 0 && !forced) ? 0 : pref)
                                  : (req[0] ? 0 : (req[1] ? 1 : -1));
      else
         win = req[owner] ? owner : -1;
      obs_gnt = {m1_gnt, m0_gnt};
      check("gnt", 32'(obs_gnt), win < 0 ? 32'd0 : 32'd1 << win);
      erv = '0; eerr = '0; erd[0] = '0; erd[1] = '0;
      e_wr = 0; e_addr = '0; e_wd = '0; e_st = '0; e_lt = '0;
      if (win >= 0) begin
         ok     = legal(we[win], typ[win], addr[win][1:0]);
         e_wr   = we[win] && ok;
         e_addr = addr[win];
         e_wd   = wdata[win];
         e_st   = we[win] ? typ[win] : 3'd0;
         e_lt   = we[win] ? 3'd0 : typ[win];
         erv[win]  = 1'b1;
         eerr[win] = !ok;
         if (ok && !we[win]) erd[win] = load_val(rmem[addr[win][5:2]], typ[win], addr[win][1:0]);
         if (e_wr) rmem[addr[win][5:2]] = store_merge(rmem[addr[win][5:2]], typ[win], addr[win][1:0], wdata[win]);
         pref = 1 - win;
         forced = 0;
         if (owner < 0) begin
            if (lock[win]) begin
               beats = 1;
               if (beats >= LOCK_MAX) forced = 1;
               else owner = win;
            end
         end else if (!lock[win]) owner = -1;
         else begin
            beats = beats < 255 ? beats + 1 : 255;
            if (beats >= LOCK_MAX) begin
               owner = -1;
               forced = 1;
            end
         end
      end else if (owner >= 0 && !lock[owner]) owner = -1;
      check("wr_en", 32'(d_wr_en), 32'(e_wr));
      check("dAddr", dAddr, e_addr);
      check("dWdata", dWdata, e_wd);
      check("store_type", 32'(store_type), 32'(e_st));
      check("load_type", 32'(load_type), 32'(e_lt));
      last_win = win;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic gen();
      for (int m = 0; m < 2; m++)
         if (!req[m] || last_win == m) begin
            if ($urandom_range(9) < 6) begin
               req[m] = 1'b1;
               we[m]  = 1'($urandom_range(1));
               typ[m] = (we[m] && $urandom_range(3) != 0) ? 3'($urandom_range(2)) : 3'($urandom_range(7));
               addr[m] = $urandom_range(1) != 0 ? 32'($urandom_range(15)) << 2 : 32'($urandom_range(63));
               wdata[m] = $urandom;
               lock[m] = $urandom_range(3) == 0;
            end else begin
               req[m]  = 1'b0;
               lock[m] = $urandom_range(7) == 0;
            end
         end
   endtask

   initial begin
      rst_n = 1'b0;
      set_req(0, 1, 0, 3'd2, 32'h0, 32'h0, 0);
      set_req(1, 0, 0, 3'd0, 32'h0, 32'h0, 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check("rst_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
      check("rst_rvalid", 32'({m1_rvalid, m0_rvalid, m1_err, m0_err}), 32'd0);
      check("rst_mem", 32'({d_wr_en, store_type, load_type}), 32'd0);
      check("rst_addr", dAddr | dWdata | m0_rdata | m1_rdata, 32'd0);
      req[0] = 1'b0;
      rst_n = 1'b1;

      // Simultaneous loads from reset: m0 first, then m1
      set_req(0, 1, 0, 3'd2, 32'h0, 32'h0, 0);
      set_req(1, 1, 0, 3'd2, 32'h4, 32'h0, 0);
      step();
      check("t2_c1_gnt", 32'(obs_gnt), 32'b01);
      check("t2_c2_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'b01);
      req[0] = 1'b0;
      step();
      check("t2_c2_gnt", 32'(obs_gnt), 32'b10);
      check("t2_c3_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'b10);
      req[1] = 1'b0;

      // Store then load back
      set_req(0, 1, 1, 3'd2, 32'h8, 32'hDEAD_BEEF, 0);
      step();
      set_req(0, 1, 0, 3'd2, 32'h8, 32'h0, 0);
      step();
      check("t1_rvalid", 32'(m0_rvalid), 32'd1);
      check("t1_rdata", m0_rdata, 32'hDEAD_BEEF);

      // Illegal accesses leave memory untouched
      set_req(0, 1, 0, 3'd1, 32'h3, 32'h0, 0);
      step();
      check("t3_lh_err", 32'({m0_err, m0_rvalid}), 32'b11);
      set_req(0, 1, 1, 3'd4, 32'h8, 32'h0, 0);
      step();
      check("t3_sb_err", 32'({m0_err, m0_rvalid}), 32'b11);
      set_req(0, 1, 0, 3'd2, 32'h8, 32'h0, 0);
      step();
      check("t3_mem", m0_rdata, 32'hDEAD_BEEF);

      // Sign and zero extension of a byte load
      set_req(0, 1, 1, 3'd2, 32'h4, 32'h0000_8000, 0);
      step();
      set_req(0, 1, 0, 3'd0, 32'h5, 32'h0, 0);
      step();
      check("t4_lb", m0_rdata, 32'hFFFF_FF80);
      set_req(0, 1, 0, 3'd4, 32'h5, 32'h0, 0);
      step();
      check("t4_lbu", m0_rdata, 32'h0000_0080);
      req[0] = 1'b0;

      // Lock limit: m1 holds for LOCK_MAX beats, then m0 gets its turn
      set_req(1, 1, 0, 3'd2, 32'h4, 32'h0, 1);
      for (int i = 0; i < 10; i++) begin
         if (i == 1) set_req(0, 1, 0, 3'd2, 32'h0, 32'h0, 0);
         step();
         check("t5_gnt", 32'(obs_gnt), i == 8 ? 32'b01 : 32'b10);
         if (i == 8) req[0] = 1'b0;
      end
      set_req(1, 0, 0, 3'd0, 32'h0, 32'h0, 0);
      step();

      for (int i = 0; i < 400; i++) begin
         gen();
         step();
      end
      set_req(0, 0, 0, 3'd0, 32'h0, 32'h0, 0);
      set_req(1, 0, 0, 3'd0, 32'h0, 32'h0, 0);
      step();
      step();

      // Reset right after a granted load drops the response
      set_req(0, 1, 0, 3'd2, 32'h0, 32'h0, 0);
      step();
      check("t6_pre_rvalid", 32'(m0_rvalid), 32'd1);
      req[0] = 1'b0;
      rst_n = 1'b0;
      #1;
      check("t6_rst_rvalid", 32'({m1_rvalid, m0_rvalid, m1_err, m0_err}), 32'd0);
      check("t6_rst_rdata", m0_rdata, 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("t6_post_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two masters: m0 (CPU load/store path) and m1 (debug/DMA loader).
- Performs same-cycle grant and drives the memory's write-enable, type, address and write-data inputs. Registers read data and returns it one cycle later.
- Rejects misaligned or illegal accesses with an error response.
- Supports a bounded lock, so one master can hold the memory for read-modify-write sequences.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin; 1 = m0 always wins when not locked by m1.
- LOCK_MAX, 8: maximum consecutive granted beats under lock before forced release (range 1..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m0_req, m1_req  in  1  access request, held until gnt
- m0_we, m1_we  in  1  1 = store, 0 = load
- m0_type, m1_type  in  3  access type (encoding in package)
- m0_addr, m1_addr  in  32  byte address
- m0_wdata, m1_wdata  in  32  store data, right-aligned
- m0_lock, m1_lock  in  1  request to keep ownership after this beat
- m0_gnt, m1_gnt  out  1  combinational; access is performed this cycle
- m0_rvalid, m1_rvalid  out  1  registered; response valid one cycle after gnt
- m0_rdata, m1_rdata  out  32  registered load data (0 for stores and errors)
- m0_err, m1_err  out  1  registered; qualifies rvalid
- d_wr_en  out  1  memory write enable
- store_type, load_type  out  3  memory type selects
- dAddr, dWdata  out  32  memory address and write data
- dRdata  in  32  memory combinational read data

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=m0, lock_cnt=0.
  - All gnt, rvalid, err = 0; rdata = 0.
  - Memory outputs idle: d_wr_en=0, types=0, dAddr=0, dWdata=0.
  - A response pending at reset is dropped.
- States:
  - IDLE: no owner.
  - LOCK0 / LOCK1: only m0 / m1 may be granted.
- Grant, IDLE, one request: that master is granted.
- Grant, IDLE, both requesting:
  - FIXED_PRIO=1: m0 wins.
  - Else: the master indicated by rr_ptr wins.
- Grant, LOCKx: only mx is granted, and only when mx_req=1. The other master waits.
- rr_ptr update: after any grant to mx, rr_ptr points to the other master.
- Granted cycle, memory drive: memory outputs take the winner's addr, wdata and type.
  - Store: d_wr_en = mx_we & legal; store_type = type.
  - Load: load_type = type.
  - The write commits at the clock edge ending the gnt cycle.
- Granted cycle, response: at that same edge, the arbiter registers rvalid=1, rdata (= dRdata for a legal load, else 0) and err (=1 if illegal) for the winner.
  - The response is visible for exactly 1 cycle; read latency is 1.
- Legality:
  - Half (001/101) requires addr[0]=0.
  - Word (010) requires addr[1:0]=00.
  - Stores accept only 000/001/010.
  - Any other type code is illegal.
  - Illegal access: gnt=1, d_wr_en=0, err response next cycle.
- Lock entry: in IDLE, a granted mx with mx_lock=1 moves to LOCKx with lock_cnt=1.
- Lock hold, in LOCKx:
  - Granted beat with mx_lock=1: lock_cnt increments.
  - Granted beat with mx_lock=0: return to IDLE.
  - Beat where lock_cnt reaches LOCK_MAX: forced return to IDLE, with rr_ptr set to the other master regardless of FIXED_PRIO for the next arbitration.
  - mx_req=0 with mx_lock=0: release to IDLE (no grant).
- Back-to-back: one grant per cycle with no bubble. A new grant may coincide with the previous beat's rvalid.
- Lock_cnt width: 8 bits, saturating.

Decomposition:
- Package dmem_pkg:
  - Type codes: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
  - arb_state_t enum {IDLE, LOCK0, LOCK1}.
  - Function is_legal(we, type, addr[1:0]).
- Sub-module: arb_rr2, a 2-way round-robin/fixed picker with pointer register. Everything else stays in dmem_arbiter.

Test Plan:
1. Reset then m0 SW addr 0x8 data 0xDEADBEEF; next cycle m0 LW 0x8 -> m0_gnt both cycles, m0_rvalid=1 with rdata=0xDEADBEEF one cycle after the load gnt.
2. Both req same cycle from reset, FIXED_PRIO=0, loads at 0x0/0x4, held -> cycle1 m0_gnt, cycle2 m1_gnt, rvalid pulses in cycles 2 and 3 respectively.
3. m0 LH addr 0x3 and m0 SB type 100 -> gnt=1, d_wr_en=0, next cycle m0_err=1, rdata=0, memory unchanged.
4. m0 LB at 0x5 with word 0x0000_8000 stored at 0x4 -> rdata=0xFFFFFF80. Same with LBU (100) -> 0x00000080.
5. m1 holds lock=1 with continuous req for 10 beats while m0 requests, LOCK_MAX=8 -> m1 granted beats 1..8, beat 9 grant goes to m0, then m1 re-arbitrates.
6. Assert rst_n=0 in the cycle after a granted load -> rvalid forced 0 immediately, state IDLE, no response after release.
